alu_seq: RTL and testbench

Registered, handshaked successor to the combinational `alu`, parametrised in data width. It executes the `alu_ops` operation set, with single-cycle logic/arithmetic and iterative one-bit-per-cycle shifts. A stored carry flag supports multi-word add/subtract chains, and valid/ready ports on both sides let it sit between an operand source and a result sink in the datapath.

---
 rtl/alu_seq.sv | 209 ++++++++++++++++++++
 tb/tb_alu_seq.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/alu_seq.sv
// Registered, handshaked ALU with a stored carry flag.
// Shifts run one bit per cycle. All other ops finish in a single cycle.
package alu_seq_pkg;
  typedef enum logic [3:0] {
    OP_ADD = 4'd0,
    OP_SUB = 4'd1,
    OP_AND = 4'd2,
    OP_OR  = 4'd3,
    OP_XOR = 4'd4,
    OP_NOT = 4'd5,
    OP_LL  = 4'd6,
    OP_LR  = 4'd7,
    OP_AL  = 4'd8,
    OP_AR  = 4'd9
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_DONE
  } state_e;
endpackage

module alu_seq
  import alu_seq_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       opcode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             use_carry,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] y,
  output logic             cout,
  output logic             overflow,
  output logic             negative,
  output logic             zero,
  output logic             err
);

  localparam int CW = $clog2(WIDTH + 1);

  state_e           state, state_n;
  logic [3:0]       op_q, op_n;
  logic [WIDTH-1:0] sh_q, sh_n;
  logic [CW-1:0]    cnt_q, cnt_n;
  logic             cf_q, cf_n;
  logic [WIDTH-1:0] y_n;
  logic             cout_n, ovf_n, neg_n, zero_n, err_n;

  logic             take;
  logic             c_eff;
  logic             is_sh;
  logic [CW-1:0]    k;
  logic [WIDTH:0]   sum, dif;
  logic [WIDTH-1:0] sh_step;
  logic             sh_out;

  assign in_ready  = (state == S_IDLE) |
                     ((state == S_DONE) & out_ready);
  assign out_valid = (state == S_DONE);
  assign take      = in_valid & in_ready;
  assign c_eff     = use_carry ? cf_q : cin;

  assign sum = {1'b0, a} + {1'b0, b} +
               {{WIDTH{1'b0}}, c_eff};
  assign dif = {1'b0, a} - {1'b0, b} -
               {{WIDTH{1'b0}}, c_eff};

  assign is_sh = (opcode == OP_LL) |
                 (opcode == OP_LR) |
                 (opcode == OP_AL) |
                 (opcode == OP_AR);

  // shift count saturates at WIDTH
  assign k = ({1'b0, b} >= (WIDTH + 1)'(WIDTH)) ?
             CW'(WIDTH) : b[CW-1:0];

  always_comb begin
    sh_step = sh_q;
    sh_out  = 1'b0;
    unique case (1'b1)
      (op_q == OP_LL) | (op_q == OP_AL): begin
        sh_step = {sh_q[WIDTH-2:0], 1'b0};
        sh_out  = sh_q[WIDTH-1];
      end
      (op_q == OP_LR): begin
        sh_step = {1'b0, sh_q[WIDTH-1:1]};
        sh_out  = sh_q[0];
      end
      default: begin
        sh_step = {sh_q[WIDTH-1], sh_q[WIDTH-1:1]};
        sh_out  = sh_q[0];
      end
    endcase
  end

  always_comb begin
    state_n = state;
    op_n    = op_q;
    sh_n    = sh_q;
    cnt_n   = cnt_q;
    cf_n    = cf_q;
    y_n     = y;
    cout_n  = cout;
    ovf_n   = overflow;
    neg_n   = negative;
    zero_n  = zero;
    err_n   = err;
    unique case (state)
      S_IDLE, S_DONE: begin
        if ((state == S_DONE) && out_ready)
          state_n = S_IDLE;
        if (take) begin
          op_n    = opcode;
          state_n = S_DONE;
          cout_n  = 1'b0;
          ovf_n   = 1'b0;
          err_n   = 1'b0;
          unique case (1'b1)
            (opcode == OP_ADD): begin
              y_n    = sum[WIDTH-1:0];
              cout_n = sum[WIDTH];
              cf_n   = sum[WIDTH];
              ovf_n  = (a[WIDTH-1] == b[WIDTH-1]) &
                       (sum[WIDTH-1] != a[WIDTH-1]);
            end
            (opcode == OP_SUB): begin
              y_n    = dif[WIDTH-1:0];
              cout_n = dif[WIDTH];
              cf_n   = dif[WIDTH];
              ovf_n  = (a[WIDTH-1] != b[WIDTH-1]) &
                       (dif[WIDTH-1] != a[WIDTH-1]);
            end
            (opcode == OP_AND): y_n = a & b;
            (opcode == OP_OR):  y_n = a | b;
            (opcode == OP_XOR): y_n = a ^ b;
            (opcode == OP_NOT): y_n = ~a;
            is_sh: begin
              if (k == '0) begin
                y_n = a;
              end else begin
                state_n = S_SHIFT;
                sh_n    = a;
                cnt_n   = k;
              end
            end
            default: begin
              y_n   = '0;
              err_n = 1'b1;
            end
          endcase
          neg_n  = y_n[WIDTH-1];
          zero_n = (y_n == '0);
        end
      end
      S_SHIFT: begin
        sh_n  = sh_step;
        cnt_n = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          state_n = S_DONE;
          y_n     = sh_step;
          cout_n  = sh_out;
          ovf_n   = 1'b0;
          err_n   = 1'b0;
          neg_n   = sh_step[WIDTH-1];
          zero_n  = (sh_step == '0);
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      op_q     <= '0;
      sh_q     <= '0;
      cnt_q    <= '0;
      cf_q     <= 1'b0;
      y        <= '0;
      cout     <= 1'b0;
      overflow <= 1'b0;
      negative <= 1'b0;
      zero     <= 1'b0;
      err      <= 1'b0;
    end else begin
      state    <= state_n;
      op_q     <= op_n;
      sh_q     <= sh_n;
      cnt_q    <= cnt_n;
      cf_q     <= cf_n;
      y        <= y_n;
      cout     <= cout_n;
      overflow <= ovf_n;
      negative <= neg_n;
      zero     <= zero_n;
      err      <= err_n;
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Randomized bench for alu_seq against an arithmetic reference model.
// Covers handshakes, carry chaining, shift latency and reset mid-op.
module tb_alu_seq;
  import alu_seq_pkg::*;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [3:0]   opcode = '0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         cin = 1'b0;
  logic         use_carry = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] y;
  logic         cout, overflow, negative, zero, err;

  alu_seq #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .opcode(opcode), .a(a), .b(b),
    .cin(cin), .use_carry(use_carry),
    .out_valid(out_valid), .out_ready(out_ready),
    .y(y), .cout(cout), .overflow(overflow),
    .negative(negative), .zero(zero), .err(err)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int cf = 0;
  bit pending = 0;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  function automatic int sgn(input int v);
    return (v >= 128) ? v - 256 : v;
  endfunction

  // reference: plain integer arithmetic on the op definitions
  task automatic model(input int op, input int av, input int bv,
                       input int c, output int ey, output int ec,
                       output int eo, output int ee, output int elat);
    int s, k;
    ey = 0; ec = 0; eo = 0; ee = 0; elat = 1;
    k = (bv > W) ? W : bv;
    case (op)
      0: begin
        s  = av + bv + c;
        ey = s % 256;
        ec = (s >= 256) ? 1 : 0;
        s  = sgn(av) + sgn(bv) + c;
        eo = (s > 127 || s < -128) ? 1 : 0;
      end
      1: begin
        s  = av - bv - c;
        ey = (s + 256) % 256;
        ec = (s < 0) ? 1 : 0;
        s  = sgn(av) - sgn(bv) - c;
        eo = (s > 127 || s < -128) ? 1 : 0;
      end
      2: ey = av & bv;
      3: ey = av | bv;
      4: ey = av ^ bv;
      5: ey = 255 - av;
      6, 8: begin
        ey = (av * (1 << k)) % 256;
        ec = (k == 0) ? 0 : (av >> (W - k)) & 1;
        elat = k + 1;
      end
      7: begin
        ey = av >> k;
        ec = (k == 0) ? 0 : (av >> (k - 1)) & 1;
        elat = k + 1;
      end
      9: begin
        ey = (sgn(av) >>> k) & 255;
        ec = (k == 0) ? 0 : (av >> (k - 1)) & 1;
        elat = k + 1;
      end
      default: ee = 1;
    endcase
  endtask

  task automatic run_op(input string tag, input int op,
                        input int av, input int bv,
                        input int ci, input int uc,
                        input int stall, input bit keep);
    int ey, ec, eo, ee, elat, lat, c;
    @(negedge clk);
    c = (uc != 0) ? cf : ci;
    model(op, av, bv, c, ey, ec, eo, ee, elat);
    opcode    = 4'(op);
    a         = 8'(av);
    b         = 8'(bv);
    cin       = ci[0];
    use_carry = uc[0];
    in_valid  = 1'b1;
    out_ready = pending;
    #1;
    check({tag, " in_ready"}, 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    opcode    = 4'($urandom);
    a         = 8'($urandom);
    b         = 8'($urandom);
    cin       = 1'($urandom);
    use_carry = 1'($urandom);
    lat = 1;
    @(negedge clk);
    while (!out_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    if (op == 0 || op == 1) cf = ec;
    check({tag, " latency"}, 32'(lat), 32'(elat));
    check({tag, " y"}, 32'(y), 32'(ey));
    check({tag, " cout"}, 32'(cout), 32'(ec));
    check({tag, " ovf"}, 32'(overflow), 32'(eo));
    check({tag, " neg"}, 32'(negative), 32'(ey >> 7));
    check({tag, " zero"}, 32'(zero), (ey == 0) ? 32'd1 : 32'd0);
    check({tag, " err"}, 32'(err), 32'(ee));
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      check({tag, " hold y"}, 32'(y), 32'(ey));
      check({tag, " hold cout"}, 32'(cout), 32'(ec));
      check({tag, " hold valid"}, 32'(out_valid), 32'd1);
      check({tag, " hold in_ready"}, 32'(in_ready), 32'd0);
    end
    if (keep) begin
      pending = 1;
    end else begin
      pending = 0;
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      check({tag, " retire"}, 32'(out_valid), 32'd0);
    end
  endtask

  initial begin
    #1;
    check("reset out_valid", 32'(out_valid), 32'd0);
    check("reset y", 32'(y), 32'd0);
    check("reset flags",
          32'({cout, overflow, negative, zero, err}), 32'd0);
    check("reset in_ready", 32'(in_ready), 32'd1);
    in_valid = 1'b1;
    opcode   = 4'(OP_NOT);
    @(posedge clk);
    #1;
    check("reset no take", 32'(out_valid), 32'd0);
    in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;

    run_op("add ovf", 0, 8'h64, 8'h5A, 0, 0, 0, 0);
    run_op("chain 1", 0, 8'hFF, 8'h01, 0, 0, 0, 0);
    run_op("chain 2", 0, 8'h00, 8'h00, 0, 1, 0, 0);
    run_op("sub bin", 1, 8'h08, 8'h03, 1, 0, 0, 0);
    run_op("sub neg", 1, 8'h03, 8'h05, 0, 0, 0, 0);
    run_op("ar 3", 9, 8'h90, 3, 0, 0, 0, 0);
    run_op("ll 9", 6, 8'h01, 9, 0, 0, 0, 0);
    run_op("lr 0", 7, 8'hA5, 0, 0, 0, 0, 0);
    run_op("illegal", 12, 8'h12, 8'h34, 0, 0, 0, 0);
    run_op("bp add", 0, 8'h11, 8'h22, 0, 0, 5, 1);
    run_op("bp xor", 4, 8'hAA, 8'hFF, 0, 0, 0, 0);

    // reset during a shift must drop the result and the carry flag
    run_op("pre rst", 0, 8'hFF, 8'h01, 0, 0, 0, 0);
    @(negedge clk);
    opcode   = 4'(OP_LR);
    a        = 8'hB5;
    b        = 8'd6;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    #1;
    check("midrst valid", 32'(out_valid), 32'd0);
    check("midrst y", 32'(y), 32'd0);
    check("midrst in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    rst = 1'b0;
    cf = 0;
    run_op("post rst", 0, 8'h01, 8'h01, 1, 1, 0, 0);

    for (int i = 0; i < 80; i++) begin
      int op, av, bv;
      op = $urandom_range(0, 11);
      av = $urandom_range(0, 255);
      if (op >= 6 && op <= 9 && $urandom_range(0, 3) != 0)
        bv = $urandom_range(0, 10);
      else
        bv = $urandom_range(0, 255);
      run_op("rand", op, av, bv,
             $urandom_range(0, 1), $urandom_range(0, 1),
             $urandom_range(0, 2), 1'($urandom_range(0, 1)));
    end
    if (pending) begin
      @(negedge clk);
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      check("drain", 32'(out_valid), 32'd0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
